// File: rtl/alu_seq.sv
// alu_seq: parametrised sequential ALU for the FPGAComputer datapath.
//
// Sixteen opcodes (the 3-bit codes 0..7 keep their legacy meaning). Single-cycle ops
// register RESULT/FLAGS and pulse DONE on the edge that samples START. OP=F is an
// unsigned multiply: a WIDTH-step shift-add engine behind a START/BUSY/DONE handshake.
//
// Build option: define ALU_MUL_EN to include the multiplier. Without it OP=F completes
// in one cycle with result 0, result_hi 0, flags 1000, and busy is tied low.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      operation request, sampled only while busy=0
//   op[3:0]    opcode, sampled with start
//   a, b       operands (accumulator / B-register side), sampled with start
//   result     registered result (low half of the product for MUL)
//   result_hi  high half of the MUL product, 0 after every other op
//   flags[3:0] registered {Z, C, N, V}
//   busy       multiply in progress
//   done       one-cycle pulse: result/flags updated this cycle
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int unsigned Msb = WIDTH - 1;
  localparam logic [WIDTH:0] OneExt = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] result_q, result_hi_q;
  logic [3:0]       flags_q;
  logic             done_q;

  // Single-cycle datapath
  logic [WIDTH:0]   ext;      // WIDTH+1-bit arithmetic; top bit is carry / borrow
  logic [WIDTH:0]   cin_ext;
  logic [WIDTH-1:0] alu_res;
  logic             c_f, v_f, wr_res;
  logic [3:0]       alu_flags;
  logic             single_go;

  assign cin_ext = {{WIDTH{1'b0}}, flags_q[2]};

  always_comb begin
    ext     = '0;
    alu_res = '0;
    c_f     = 1'b0;
    v_f     = 1'b0;
    wr_res  = 1'b1;
    case (op)
      4'h0: begin // ADD
        ext     = {1'b0, a} + {1'b0, b};
        alu_res = ext[Msb:0];
        c_f     = ext[WIDTH];
        v_f     = (a[Msb] == b[Msb]) && (ext[Msb] != a[Msb]);
      end
      4'h1: begin // SUB
        ext     = {1'b0, a} - {1'b0, b};
        alu_res = ext[Msb:0];
        c_f     = ext[WIDTH];
        v_f     = (a[Msb] != b[Msb]) && (ext[Msb] != a[Msb]);
      end
      4'h2: begin // DEC
        ext     = {1'b0, a} - OneExt;
        alu_res = ext[Msb:0];
        c_f     = ext[WIDTH];
        v_f     = a[Msb] && !ext[Msb];
      end
      4'h3: begin // INC
        ext     = {1'b0, a} + OneExt;
        alu_res = ext[Msb:0];
        c_f     = ext[WIDTH];
        v_f     = !a[Msb] && ext[Msb];
      end
      4'h4: alu_res = ~a;
      4'h5: alu_res = a & b;
      4'h6: alu_res = a | b;
      4'h7: alu_res = a ^ b;
      4'h8: begin // ADC
        ext     = {1'b0, a} + {1'b0, b} + cin_ext;
        alu_res = ext[Msb:0];
        c_f     = ext[WIDTH];
        v_f     = (a[Msb] == b[Msb]) && (ext[Msb] != a[Msb]);
      end
      4'h9: begin // SBB
        ext     = {1'b0, a} - {1'b0, b} - cin_ext;
        alu_res = ext[Msb:0];
        c_f     = ext[WIDTH];
        v_f     = (a[Msb] != b[Msb]) && (ext[Msb] != a[Msb]);
      end
      4'hA: begin // SHL
        alu_res = {a[WIDTH-2:0], 1'b0};
        c_f     = a[Msb];
      end
      4'hB: begin // SHR
        alu_res = {1'b0, a[Msb:1]};
        c_f     = a[0];
      end
      4'hC: begin // ROL
        alu_res = {a[WIDTH-2:0], a[Msb]};
        c_f     = a[Msb];
      end
      4'hD: begin // ROR
        alu_res = {a[0], a[Msb:1]};
        c_f     = a[0];
      end
      4'hE: begin // CMP: flags from the difference, result register untouched
        ext     = {1'b0, a} - {1'b0, b};
        alu_res = ext[Msb:0];
        c_f     = ext[WIDTH];
        v_f     = (a[Msb] != b[Msb]) && (ext[Msb] != a[Msb]);
        wr_res  = 1'b0;
      end
      4'hF: alu_res = '0; // only reached here when the multiplier is not built
    endcase
  end

  assign alu_flags = {alu_res == '0, c_f, alu_res[Msb], v_f};

`ifdef ALU_MUL_EN
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMul  = 1'b1;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  logic [0:0]         state_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  // Upper half is the accumulator, lower half shifts the multiplier out LSB first
  logic [2*WIDTH-1:0] prod_q, prod_nxt;
  logic [WIDTH:0]     upper_sum;
  logic               mul_start, mul_fin, hi_nz;

  assign single_go = start && (state_q == StIdle) && (op != 4'hF);
  assign mul_start = start && (state_q == StIdle) && (op == 4'hF);
  assign mul_fin   = (state_q == StMul) && (cnt_q == LastStep);

  always_comb begin
    upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nxt  = {upper_sum, prod_q[Msb:1]};
  end

  assign hi_nz = |prod_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (mul_start) begin
      state_q <= StMul;
      cnt_q   <= '0;
      mcand_q <= a;
      prod_q  <= {{WIDTH{1'b0}}, b};
    end else if (state_q == StMul) begin
      prod_q <= prod_nxt;
      cnt_q  <= cnt_q + CntW'(1);
      if (mul_fin) state_q <= StIdle;
    end
  end

  assign busy = (state_q == StMul);
`else
  assign single_go = start;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (single_go) begin
        if (wr_res) result_q <= alu_res;
        result_hi_q <= '0;
        flags_q     <= alu_flags;
        done_q      <= 1'b1;
      end
`ifdef ALU_MUL_EN
      if (mul_fin) begin
        result_q    <= prod_nxt[Msb:0];
        result_hi_q <= prod_nxt[2*WIDTH-1:WIDTH];
        flags_q     <= {prod_nxt == '0, hi_nz, 1'b0, hi_nz};
        done_q      <= 1'b1;
      end
`endif
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vector table, hand-written
// multiply/reset sequences, then random ops against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;
  localparam longint Mod  = longint'(1) << W;
  localparam longint Half = longint'(1) << (W - 1);

  logic         clk, rst_n, start, busy, done;
  logic [3:0]   op, flags;
  logic [W-1:0] a, b, result, result_hi;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [W-1:0] m_res, m_hi;
  logic [3:0]   m_flags;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .result(result), .result_hi(result_hi), .flags(flags), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic longint to_signed(input longint u);
    return (u >= Half) ? u - Mod : u;
  endfunction

  // Behavioural model: plain integer arithmetic on the opcode's meaning.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint ux = longint'(x), uy = longint'(y), ci = longint'(m_flags[2]);
    longint sx = to_signed(ux), sy = to_signed(uy);
    longint r = 0, sr = 0, rm, p;
    bit c = 0, arith = 0;
    case (o)
      4'h0: begin r = ux + uy; sr = sx + sy; c = r >= Mod; arith = 1; end
      4'h1, 4'hE: begin r = ux - uy; sr = sx - sy; c = r < 0; arith = 1; end
      4'h2: begin r = ux - 1; sr = sx - 1; c = r < 0; arith = 1; end
      4'h3: begin r = ux + 1; sr = sx + 1; c = r >= Mod; arith = 1; end
      4'h4: r = Mod - 1 - ux;
      4'h5: r = ux & uy;
      4'h6: r = ux | uy;
      4'h7: r = ux ^ uy;
      4'h8: begin r = ux + uy + ci; sr = sx + sy + ci; c = r >= Mod; arith = 1; end
      4'h9: begin r = ux - uy - ci; sr = sx - sy - ci; c = r < 0; arith = 1; end
      4'hA: begin r = ux * 2; c = ux >= Half; end
      4'hB: begin r = ux / 2; c = (ux % 2) == 1; end
      4'hC: begin r = ux * 2 + ux / Half; c = ux >= Half; end
      4'hD: begin r = ux / 2 + (ux % 2) * Half; c = (ux % 2) == 1; end
      default: ;
    endcase
    if (o == 4'hF) begin
`ifdef ALU_MUL_EN
      p = ux * uy;
      m_res = W'(p % Mod);
      m_hi  = W'(p / Mod);
      m_flags = {p == 0, m_hi != 0, 1'b0, m_hi != 0};
`else
      p = 0;
      m_res = '0;
      m_hi  = '0;
      m_flags = 4'b1000;
`endif
    end else begin
      rm = ((r % Mod) + Mod) % Mod;
      if (o != 4'hE) m_res = W'(rm);
      m_hi = '0;
      m_flags = {rm == 0, c, rm >= Half, arith && (sr < -Half || sr > Half - 1)};
    end
  endtask

  // Issue one op and wait until its result is due; checks busy during a multiply.
  task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    model(o, x, y);
`ifdef ALU_MUL_EN
    if (o == 4'hF) begin
      for (int i = 0; i < W; i++) begin
        check("mul busy/done", {busy, done}, 2'b10);
        @(posedge clk); #1;
      end
    end
`endif
  endtask

  task automatic check_model(input string tag);
    check({tag, " result"}, result, m_res);
    check({tag, " result_hi"}, result_hi, m_hi);
    check({tag, " flags"}, flags, m_flags);
    check({tag, " done"}, done, 1);
    check({tag, " busy"}, busy, 0);
  endtask

  typedef struct {
    string        name;
    logic [3:0]   o;
    logic [W-1:0] x, y, res;
    logic [3:0]   flg;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [3:0] o, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W-1:0] res,
                              input logic [3:0] flg);
    vec_t v;
    v.name = n; v.o = o; v.x = x; v.y = y; v.res = res; v.flg = flg;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    bit   saw_done;
    int   t_o;
    logic [W-1:0] t_x, t_y;

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    m_res = '0; m_hi = '0; m_flags = '0;
    #12;
    check("reset result", result, 0);
    check("reset result_hi", result_hi, 0);
    check("reset flags", flags, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk); rst_n = 1'b1;

    // Chained sequence: carries flow from one entry into the next ADC/SBB.
    tbl.push_back(mk("add",  4'h0, 8'hAA, 8'h55, 8'hFF, 4'b0010));
    tbl.push_back(mk("sub",  4'h1, 8'hAA, 8'h55, 8'h55, 4'b0001));
    tbl.push_back(mk("cmp",  4'hE, 8'h10, 8'h20, 8'h55, 4'b0110));
    tbl.push_back(mk("inc",  4'h3, 8'hFF, 8'h00, 8'h00, 4'b1100));
    tbl.push_back(mk("adc",  4'h8, 8'h00, 8'h00, 8'h01, 4'b0000));
    tbl.push_back(mk("dec",  4'h2, 8'h00, 8'h00, 8'hFF, 4'b0110));
    tbl.push_back(mk("shl",  4'hA, 8'h81, 8'h00, 8'h02, 4'b0100));
    tbl.push_back(mk("ror",  4'hD, 8'h01, 8'h00, 8'h80, 4'b0110));
    tbl.push_back(mk("oc",   4'h4, 8'hAA, 8'h00, 8'h55, 4'b0000));
    tbl.push_back(mk("xor",  4'h7, 8'hAA, 8'hFF, 8'h55, 4'b0000));
    tbl.push_back(mk("and",  4'h5, 8'hF0, 8'h0F, 8'h00, 4'b1000));
    tbl.push_back(mk("or",   4'h6, 8'hF0, 8'h0F, 8'hFF, 4'b0010));
    tbl.push_back(mk("sbb0", 4'h9, 8'h00, 8'h01, 8'hFF, 4'b0110));
    tbl.push_back(mk("sbb1", 4'h9, 8'h80, 8'h00, 8'h7F, 4'b0001));
    tbl.push_back(mk("rol",  4'hC, 8'h80, 8'h00, 8'h01, 4'b0100));
    tbl.push_back(mk("shr",  4'hB, 8'h01, 8'h00, 8'h00, 4'b1100));
    tbl.push_back(mk("addv", 4'h0, 8'h7F, 8'h01, 8'h80, 4'b0011));

    foreach (tbl[i]) begin
      drive(tbl[i].o, tbl[i].x, tbl[i].y);
      check({tbl[i].name, " result"}, result, tbl[i].res);
      check({tbl[i].name, " result_hi"}, result_hi, 0);
      check({tbl[i].name, " flags"}, flags, tbl[i].flg);
      check({tbl[i].name, " done"}, done, 1);
    end
    @(posedge clk); #1;
    check("done clears", done, 0);
    check("result holds", result, 8'h80);

`ifdef ALU_MUL_EN
    // MUL with a competing ADD request held high and operands changing while busy.
    @(negedge clk);
    start = 1'b1; op = 4'hF; a = 8'h0F; b = 8'h11;
    @(posedge clk); #1;
    op = 4'h0; a = 8'h01; b = 8'h01;
    model(4'hF, 8'h0F, 8'h11);
    for (int i = 0; i < W; i++) begin
      check("mul ignore busy/done", {busy, done}, 2'b10);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_model("mul 0Fx11");
    check("mul 0Fx11 value", {result_hi, result}, 16'h00FF);
    @(posedge clk); #1;
    check("mul no queued op done", done, 0);
    check("mul no queued op result", result, 8'hFF);

    drive(4'hF, 8'hFF, 8'hFF);
    check_model("mul FFxFF");
    check("mul FFxFF value", {flags, result_hi, result}, {4'b0101, 16'hFE01});

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 4'hF; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midmul reset outputs", {result, result_hi, flags, busy, done}, 0);
    m_res = '0; m_hi = '0; m_flags = '0;
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("midmul no done after reset", saw_done, 0);
`else
    drive(4'hF, 8'h12, 8'h34);
    check("mulopt result", {result_hi, result}, 0);
    check("mulopt flags", flags, 4'b1000);
    check("mulopt done", done, 1);
    check("mulopt busy", busy, 0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("reset2 outputs", {result, result_hi, flags, busy, done}, 0);
    m_res = '0; m_hi = '0; m_flags = '0;
    @(negedge clk); rst_n = 1'b1;
`endif
    drive(4'h0, 8'h01, 8'h01);
    check("post-reset add", result, 8'h02);
    check_model("post-reset add");

    // Random ops, chained back to back, against the model.
    for (int i = 0; i < 300; i++) begin
      t_o = int'($urandom_range(0, 15));
      t_x = W'($urandom);
      t_y = W'($urandom);
      drive(4'(t_o), t_x, t_y);
      check_model($sformatf("rand%0d op%0h", i, t_o));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
